// File: rtl/ring_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ring_sweep_ctrl
// Purpose  : Tap sequencer and windowed edge counter for the tapped ring
//            oscillator; optional sweep min/max tracking under SWEEP_MINMAX_EN.
// Revision : 1.0
// ============================================================================
module ring_sweep_ctrl #(
   parameter int WINDOW_LOG2   = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             single,
   input  logic [2:0]       tap_sel,
   input  logic             abort,
   input  logic             osc_in,
   output logic [2:0]       tap,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic [2:0]       result_tap,
   output logic             result_valid,
   output logic             overflow,
   output logic             done,
   output logic [2:0]       min_tap,
   output logic [2:0]       max_tap
);

   localparam int C_WIN   = 1 << WINDOW_LOG2;
   localparam int C_SPAN  = (C_WIN > SETTLE_CYCLES) ? C_WIN : SETTLE_CYCLES;
   localparam int C_CYC_W = $clog2(C_SPAN);

   localparam logic [C_CYC_W-1:0] C_SETTLE_LAST = C_CYC_W'(SETTLE_CYCLES - 1);
   localparam logic [C_CYC_W-1:0] C_WIN_LAST    = C_CYC_W'(C_WIN - 1);
   localparam logic [C_CYC_W-1:0] C_GATE_END    = C_CYC_W'(C_WIN - 3);
   localparam logic [C_CYC_W-1:0] C_CYC_ONE     = C_CYC_W'(1);
   localparam logic [CNT_W-1:0]   C_CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]   C_CNT_MAX     = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_REPORT  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [C_CYC_W-1:0] cyc_q, cyc_d;
   logic [2:0]         sync_q;
   logic [2:0]         tap_q, tap_d;
   logic               single_q, single_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sat_q, sat_d;
   logic [CNT_W-1:0]   result_q, result_d;
   logic [2:0]         rtap_q, rtap_d;
   logic               ovf_q, ovf_d;
   logic               rvalid_q, rvalid_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic w_edge;
   logic w_meas_end;

   // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history flop
   assign w_edge     = sync_q[1] & ~sync_q[2];
   assign w_meas_end = (state_q == S_MEASURE) && (cyc_q == C_WIN_LAST) && !abort;

   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q + C_CYC_ONE;
      tap_d    = tap_q;
      single_d = single_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      result_d = result_q;
      rtap_d   = rtap_q;
      ovf_d    = ovf_q;
      rvalid_d = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            cyc_d = '0;
            if (start && !abort) begin
               tap_d    = single ? tap_sel : 3'd0;
               single_d = single;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = '0;
            sat_d = 1'b0;
            if (cyc_q == C_SETTLE_LAST) begin
               cyc_d   = '0;
               state_d = S_MEASURE;
            end
         end
         S_MEASURE: begin
            // The last three window cycles would only see edges that began
            // before the window closed, so they are dropped.
            if (w_edge && (cyc_q < C_GATE_END)) begin
               if (cnt_q == C_CNT_MAX) begin
                  sat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + C_CNT_ONE;
               end
            end
            if (cyc_q == C_WIN_LAST) begin
               cyc_d    = '0;
               state_d  = S_REPORT;
               result_d = cnt_q;
               rtap_d   = tap_q;
               ovf_d    = sat_q;
               rvalid_d = 1'b1;
               done_d   = single_q || (tap_q == 3'd7);
            end
         end
         S_REPORT: begin
            cyc_d = '0;
            if (single_q || (tap_q == 3'd7)) begin
               state_d = S_IDLE;
            end else begin
               tap_d   = tap_q + 3'd1;
               state_d = S_SETTLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         cyc_d    = '0;
         tap_d    = tap_q;
         result_d = result_q;
         rtap_d   = rtap_q;
         ovf_d    = ovf_q;
         rvalid_d = 1'b0;
         done_d   = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cyc_q    <= '0;
         sync_q   <= '0;
         tap_q    <= '0;
         single_q <= 1'b0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         result_q <= '0;
         rtap_q   <= '0;
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         sync_q   <= {sync_q[1:0], osc_in};
         tap_q    <= tap_d;
         single_q <= single_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
         result_q <= result_d;
         rtap_q   <= rtap_d;
         ovf_q    <= ovf_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign tap          = tap_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_tap   = rtap_q;
   assign result_valid = rvalid_q;
   assign overflow     = ovf_q;
   assign done         = done_q;

`ifdef SWEEP_MINMAX_EN
   logic [CNT_W-1:0] lo_val_q, lo_val_d, hi_val_q, hi_val_d;
   logic [2:0]       lo_tap_q, lo_tap_d, hi_tap_q, hi_tap_d;
   logic [2:0]       min_tap_q, min_tap_d, max_tap_q, max_tap_d;
   logic             w_lo_new, w_hi_new;

   // Strict compares keep the lower tap on ties; tap 0 seeds the running values.
   assign w_lo_new = (tap_q == 3'd0) || (cnt_q < lo_val_q);
   assign w_hi_new = (tap_q == 3'd0) || (cnt_q > hi_val_q);

   always_comb begin
      lo_val_d  = lo_val_q;
      hi_val_d  = hi_val_q;
      lo_tap_d  = lo_tap_q;
      hi_tap_d  = hi_tap_q;
      min_tap_d = min_tap_q;
      max_tap_d = max_tap_q;
      if (w_meas_end && !single_q) begin
         if (w_lo_new) begin
            lo_val_d = cnt_q;
            lo_tap_d = tap_q;
         end
         if (w_hi_new) begin
            hi_val_d = cnt_q;
            hi_tap_d = tap_q;
         end
         if (tap_q == 3'd7) begin
            min_tap_d = w_lo_new ? tap_q : lo_tap_q;
            max_tap_d = w_hi_new ? tap_q : hi_tap_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_val_q  <= '0;
         hi_val_q  <= '0;
         lo_tap_q  <= '0;
         hi_tap_q  <= '0;
         min_tap_q <= '0;
         max_tap_q <= '0;
      end else begin
         lo_val_q  <= lo_val_d;
         hi_val_q  <= hi_val_d;
         lo_tap_q  <= lo_tap_d;
         hi_tap_q  <= hi_tap_d;
         min_tap_q <= min_tap_d;
         max_tap_q <= max_tap_d;
      end
   end

   assign min_tap = min_tap_q;
   assign max_tap = max_tap_q;
`else
   assign min_tap = 3'd0;
   assign max_tap = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_sweep_ctrl.sv
`default_nettype none
// Directed testbench for ring_sweep_ctrl (defaults plus a CNT_W=6 instance for saturation).
module tb_ring_sweep_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, start, single, abort, osc_in;
   logic [2:0]  tap_sel;
   logic [2:0]  tap, result_tap, min_tap, max_tap;
   logic        busy, result_valid, overflow, done;
   logic [11:0] result;
   logic [2:0]  s_tap, s_result_tap, s_min_tap, s_max_tap;
   logic        s_busy, s_result_valid, s_overflow, s_done;
   logic [5:0]  s_result;

   int n_cmp = 0;
   int n_err = 0;
   int pcnt = 0;
   int t0 = 0;
   int rv_n = 0;
   int done_n = 0;
   int done_cyc = -1;
   int rv_cyc [16];
   int rv_res [16];
   int rv_tap [16];
   logic rv_done [16];
   int osc_mode = 0;
   int fixed_per = 4;
   int exp_min = 0;
   int exp_max = 0;

   ring_sweep_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .single(single), .tap_sel(tap_sel),
      .abort(abort), .osc_in(osc_in), .tap(tap), .busy(busy), .result(result),
      .result_tap(result_tap), .result_valid(result_valid), .overflow(overflow),
      .done(done), .min_tap(min_tap), .max_tap(max_tap)
   );

   ring_sweep_ctrl #(.CNT_W(6)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .single(single), .tap_sel(tap_sel),
      .abort(abort), .osc_in(osc_in), .tap(s_tap), .busy(s_busy), .result(s_result),
      .result_tap(s_result_tap), .result_valid(s_result_valid), .overflow(s_overflow),
      .done(s_done), .min_tap(s_min_tap), .max_tap(s_max_tap)
   );

   always #5 clk = ~clk;
   always @(posedge clk) pcnt <= pcnt + 1;

   always @(negedge clk) begin
      if (result_valid) begin
         if (rv_n < 16) begin
            rv_cyc[rv_n]  = pcnt - t0;
            rv_res[rv_n]  = int'(result);
            rv_tap[rv_n]  = int'(result_tap);
            rv_done[rv_n] = done;
         end
         rv_n = rv_n + 1;
      end
      if (done) begin
         done_n   = done_n + 1;
         done_cyc = pcnt - t0;
      end
   end

   // Ring model: mode 1 fixed period, mode 2 period 2*(tap+2); phase restarts on tap change.
   initial begin : osc_gen
      int ph;
      int per;
      logic [2:0] last_tap;
      logic last_busy;
      logic restart;
      ph = 0; last_tap = 3'd0; last_busy = 1'b0; osc_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         per = (osc_mode == 2) ? 2 * (int'(tap) + 2) : ((osc_mode == 1) ? fixed_per : 0);
         restart = (tap != last_tap) || (busy && !last_busy);
         last_tap = tap;
         last_busy = busy;
         if (per == 0) begin
            osc_in = 1'b0;
         end else begin
            if (restart) ph = 0;
            else ph = (ph + 1 >= per) ? 0 : ph + 1;
            osc_in = (ph < per / 2);
         end
      end
   end

   task automatic drive_start(input logic sgl, input logic [2:0] ts);
      @(negedge clk);
      start = 1'b1; single = sgl; tap_sel = ts;
      t0 = pcnt; rv_n = 0; done_n = 0; done_cyc = -1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cycle(input int c);
      while (pcnt - t0 < c) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (tap !== 3'd0) begin n_err++; $display("FAIL rst_tap: got %0d want 0", tap); end
      n_cmp++; if (result !== 12'd0) begin n_err++; $display("FAIL rst_result: got %0d want 0", result); end
      n_cmp++; if ({result_valid, done, overflow} !== 3'b000) begin
         n_err++; $display("FAIL rst_flags: got %b want 000", {result_valid, done, overflow}); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      osc_mode = 1; fixed_per = 4;
      drive_start(1'b1, 3'd5);
      n_cmp++; if (tap !== 3'd5) begin n_err++; $display("FAIL single_tap_c1: got %0d want 5", tap); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_c1: got %b want 1", busy); end
      wait_cycle(272);
      n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL single_rv_early: got %b want 0", result_valid); end
      wait_cycle(273);
      n_cmp++; if ({result_valid, done} !== 2'b11) begin
         n_err++; $display("FAIL single_rv_done: got %b want 11", {result_valid, done}); end
      n_cmp++; if (result < 12'd63 || result > 12'd65) begin
         n_err++; $display("FAIL single_result: got %0d want 63..65", result); end
      n_cmp++; if (result_tap !== 3'd5) begin n_err++; $display("FAIL single_rtap: got %0d want 5", result_tap); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", overflow); end
      wait_cycle(274);
      n_cmp++; if ({busy, result_valid, done} !== 3'b000) begin
         n_err++; $display("FAIL single_end: got busy/rv/done %b want 000", {busy, result_valid, done}); end
   endtask

   task automatic test_sweep();
      int e;
      osc_mode = 2;
      drive_start(1'b0, 3'd4);
      n_cmp++; if (tap !== 3'd0) begin n_err++; $display("FAIL sweep_tap_c1: got %0d want 0", tap); end
      wait_cycle(2183);
      n_cmp++; if (min_tap !== 3'd0) begin n_err++; $display("FAIL sweep_min_early: got %0d want 0", min_tap); end
      wait_cycle(2184);
      n_cmp++; if ({done, busy} !== 2'b11) begin n_err++; $display("FAIL sweep_done: got done/busy %b want 11", {done, busy}); end
      n_cmp++; if (int'(min_tap) !== exp_min) begin n_err++; $display("FAIL sweep_min_tap: got %0d want %0d", min_tap, exp_min); end
      n_cmp++; if (int'(max_tap) !== exp_max) begin n_err++; $display("FAIL sweep_max_tap: got %0d want %0d", max_tap, exp_max); end
      wait_cycle(2185);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_busy_fall: got %b want 0", busy); end
      n_cmp++; if (rv_n !== 8) begin n_err++; $display("FAIL sweep_rv_count: got %0d want 8", rv_n); end
      n_cmp++; if (done_n !== 1 || done_cyc !== 2184) begin
         n_err++; $display("FAIL sweep_done_once: got %0d pulses at %0d want 1 at 2184", done_n, done_cyc); end
      for (int k = 0; k < 8 && k < rv_n; k++) begin
         e = 256 / (2 * k + 4);
         n_cmp++; if (rv_cyc[k] !== 273 * (k + 1)) begin
            n_err++; $display("FAIL sweep_rv_cycle[%0d]: got %0d want %0d", k, rv_cyc[k], 273 * (k + 1)); end
         n_cmp++; if (rv_tap[k] !== k) begin n_err++; $display("FAIL sweep_rtap[%0d]: got %0d want %0d", k, rv_tap[k], k); end
         n_cmp++; if (rv_res[k] < e - 2 || rv_res[k] > e + 2) begin
            n_err++; $display("FAIL sweep_result[%0d]: got %0d want %0d+-2", k, rv_res[k], e); end
         n_cmp++; if (rv_done[k] !== (k == 7)) begin
            n_err++; $display("FAIL sweep_done_at[%0d]: got %b want %b", k, rv_done[k], (k == 7)); end
      end
   endtask

   task automatic test_saturation();
      osc_mode = 1; fixed_per = 2;
      drive_start(1'b1, 3'd1);
      wait_cycle(273);
      n_cmp++; if (s_result_valid !== 1'b1) begin n_err++; $display("FAIL sat_rv: got %b want 1", s_result_valid); end
      n_cmp++; if (s_result !== 6'd63) begin n_err++; $display("FAIL sat_result: got %0d want 63", s_result); end
      n_cmp++; if (s_overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b want 1", s_overflow); end
      n_cmp++; if (s_result_tap !== 3'd1) begin n_err++; $display("FAIL sat_rtap: got %0d want 1", s_result_tap); end
      n_cmp++; if (result < 12'd125 || result > 12'd129 || overflow !== 1'b0) begin
         n_err++; $display("FAIL wide_result: got %0d ovf %b want 125..129 ovf 0", result, overflow); end
      n_cmp++; if (int'(min_tap) !== exp_min) begin n_err++; $display("FAIL single_keeps_min: got %0d want %0d", min_tap, exp_min); end
      wait_cycle(274);
   endtask

   task automatic test_abort();
      osc_mode = 1; fixed_per = 4;
      drive_start(1'b1, 3'd2);
      wait_cycle(50);
      start = 1'b1; single = 1'b0; tap_sel = 3'd6;
      @(negedge clk);
      start = 1'b0;
      wait_cycle(60);
      n_cmp++; if ({busy, tap} !== {1'b1, 3'd2}) begin
         n_err++; $display("FAIL ignore_start: got busy %b tap %0d want 1 2", busy, tap); end
      wait_cycle(100);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_c101: got %b want 0", busy); end
      n_cmp++; if (tap !== 3'd2) begin n_err++; $display("FAIL abort_tap_kept: got %0d want 2", tap); end
      n_cmp++; if ({s_result, s_overflow, s_result_tap} !== {6'd63, 1'b1, 3'd1}) begin
         n_err++; $display("FAIL abort_result_kept: got %0d/%b/%0d want 63/1/1", s_result, s_overflow, s_result_tap); end
      wait_cycle(300);
      n_cmp++; if (rv_n !== 0 || done_n !== 0) begin
         n_err++; $display("FAIL abort_no_pulses: got rv %0d done %0d want 0 0", rv_n, done_n); end
   endtask

   task automatic test_abort_report();
      osc_mode = 2;
      drive_start(1'b0, 3'd0);
      wait_cycle(273);
      n_cmp++; if ({result_valid, done, result_tap} !== {1'b1, 1'b0, 3'd0}) begin
         n_err++; $display("FAIL abrep_rv: got rv %b done %b rtap %0d want 1 0 0", result_valid, done, result_tap); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if ({busy, tap} !== {1'b0, 3'd0}) begin
         n_err++; $display("FAIL abrep_stop: got busy %b tap %0d want 0 0", busy, tap); end
      wait_cycle(600);
      n_cmp++; if (rv_n !== 1 || done_n !== 0 || busy !== 1'b0) begin
         n_err++; $display("FAIL abrep_no_more: got rv %0d done %0d busy %b want 1 0 0", rv_n, done_n, busy); end
      n_cmp++; if (int'(min_tap) !== exp_min || int'(max_tap) !== exp_max) begin
         n_err++; $display("FAIL abrep_minmax_kept: got %0d/%0d want %0d/%0d", min_tap, max_tap, exp_min, exp_max); end
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      start = 1'b1; single = 1'b1; tap_sel = 3'd3; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      n_cmp++; if ({busy, tap} !== {1'b0, 3'd0}) begin
         n_err++; $display("FAIL start_abort_idle: got busy %b tap %0d want 0 0", busy, tap); end
   endtask

   task automatic test_reset_midmeasure();
      osc_mode = 1; fixed_per = 4;
      drive_start(1'b1, 3'd6);
      wait_cycle(100);
      n_cmp++; if ({busy, tap} !== {1'b1, 3'd6}) begin
         n_err++; $display("FAIL rstm_pre: got busy %b tap %0d want 1 6", busy, tap); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({tap, busy, result_tap, result_valid, overflow, done, min_tap, max_tap} !== 15'd0) begin
         n_err++; $display("FAIL rstm_outputs: got tap %0d busy %b rtap %0d rv %b ovf %b done %b min %0d max %0d want all 0",
                           tap, busy, result_tap, result_valid, overflow, done, min_tap, max_tap); end
      n_cmp++; if (result !== 12'd0 || s_result !== 6'd0) begin
         n_err++; $display("FAIL rstm_result: got %0d/%0d want 0/0", result, s_result); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy, tap, result_valid} !== 5'd0) begin
         n_err++; $display("FAIL rstm_idle: got busy %b tap %0d rv %b want 0 0 0", busy, tap, result_valid); end
   endtask

   initial begin
`ifdef SWEEP_MINMAX_EN
      exp_min = 7; exp_max = 0;
`else
      exp_min = 0; exp_max = 0;
`endif
      rst_n = 1'b1; start = 1'b0; single = 1'b0; tap_sel = 3'd0; abort = 1'b0;
      #1 rst_n = 1'b0;
      test_reset();
      test_single();
      test_sweep();
      test_saturation();
      test_abort();
      test_abort_report();
      test_start_abort_idle();
      test_reset_midmeasure();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ring_sweep_ctrl.md
# ring_sweep_ctrl

Measurement sequencer for the tapped ring oscillator. Drives the 3-bit tap select, lets the ring settle, counts oscillator rising edges over a fixed window of `clk` cycles, and reports one count per tap. It runs either a single tap or a full 0..7 sweep. It sits between the ring macro and the top-level I/O, replacing direct `ui_in` tap control and the free-running edge counter.

## Interface

Parameters:

- `WINDOW_LOG2`, default 8: measurement window is 2^WINDOW_LOG2 `clk` cycles.
- `SETTLE_CYCLES`, default 16: cycles held after each tap change before counting; legal range ≥ 1.
- `CNT_W`, default 12: result counter width.

Ports:

- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sampled in IDLE only; begins an operation.
- `single` in 1: sampled with `start`. 1 measures `tap_sel` once; 0 sweeps taps 0..7.
- `tap_sel` in 3: tap used for a single measurement.
- `abort` in 1: synchronous; cancels any operation.
- `osc_in` in 1: ring output, already prescaled. Asynchronous to `clk`; frequency must be < f_clk/2.
- `tap` out 3: drives ring tap select.
- `busy` out 1: high from the cycle after accepted `start` until return to IDLE.
- `result` out CNT_W: last completed count, held until the next REPORT.
- `result_tap` out 3: tap that produced `result`.
- `result_valid` out 1: one-cycle pulse in REPORT.
- `overflow` out 1: count for `result` saturated.
- `done` out 1: one-cycle pulse at the final REPORT of an operation.
- `min_tap`, `max_tap` out 3: sweep extremes; see Configuration.

## Operation

- `osc_in` passes through a 2-flop synchronizer, then a rising-edge detector (third flop). Each detected edge increments the window counter.
- States are IDLE, SETTLE, MEASURE and REPORT.
  - IDLE: on `start`, load `tap` with `tap_sel` if `single`=1, else with 0. Go to SETTLE.
  - SETTLE: runs SETTLE_CYCLES cycles. The edge counter is held at 0. Go to MEASURE.
  - MEASURE: runs 2^WINDOW_LOG2 cycles, counting edges.
  - REPORT: 1 cycle.
    - `result` ← count; `result_tap` ← `tap`; `overflow` ← saturation flag; `result_valid`=1.
    - If single, or `tap`=7, assert `done` and go to IDLE.
    - Otherwise `tap`+1 and go to SETTLE.
- The counter saturates at 2^CNT_W−1 and sets the saturation flag. It never wraps.
- Edges that fall within the final 3 cycles of the window because of synchronizer latency are discarded. The counter clears in SETTLE.
- `start` while `busy` is ignored. `start` and `abort` in the same IDLE cycle: `abort` wins, no operation starts.
- `abort` in any non-IDLE state:
  - Next cycle is IDLE with `busy`=0.
  - No `result_valid` and no `done` are issued.
  - `result`, `result_tap`, `overflow` and `tap` keep their current values.
- `abort` in a REPORT cycle still lets that cycle's `result_valid` and update happen. No further taps follow.
- Reset, at any time, returns to IDLE immediately. All outputs take reset values: `tap`=0, `busy`=0, `result`=0, `result_tap`=0, `result_valid`=0, `overflow`=0, `done`=0, `min_tap`=0, `max_tap`=0. Synchronizer flops clear to 0.

## Timing

- Cycle 0 is the cycle where `start` is sampled. `busy` and the new `tap` appear at cycle 1.
- Per tap: SETTLE occupies cycles 1..S, MEASURE cycles S+1..S+W, REPORT cycle S+W+1. S = SETTLE_CYCLES, W = 2^WINDOW_LOG2.
- Per-tap period P = S+W+1. Defaults give P = 273.
- Sweep: tap k reports at cycle (k+1)·P. `done` coincides with the tap-7 `result_valid` at cycle 8P (2184 with defaults). `busy` falls at 8P+1.
- Single measurement: `done` at cycle P; `busy` falls at P+1.
- A new `start` is accepted from the first IDLE cycle after `busy` falls.

## Configuration

- `SWEEP_MINMAX_EN` defined:
  - During a sweep, the block tracks the taps with the smallest and largest `result`. Ties keep the lower tap.
  - `min_tap` and `max_tap` update together at the `done` cycle of a sweep.
  - Single measurements and aborted sweeps leave them unchanged.
- Not defined: tracking logic is absent and `min_tap`/`max_tap` are tied to 0.

## Test plan

- Reset check: assert `rst_n`=0 mid-MEASURE → all outputs at reset values in the same cycle; after release, IDLE with `busy`=0.
- Single measurement: `osc_in` rising every 4 `clk`, `start`=1, `single`=1, `tap_sel`=5 → `tap`=5 at cycle 1, `result_valid` and `done` at cycle 273, `result`=64±1, `result_tap`=5, `overflow`=0.
- Sweep: `osc_in` period of 2·(k+2) cycles when `tap`=k → 8 `result_valid` pulses at 273·(k+1), `result_tap`=0..7 in order, `result` ≈ 256/(2k+4); `done` at 2184 only.
- Saturation: CNT_W=6, `osc_in` rising every 2 cycles, single → `result`=63, `overflow`=1.
- Abort/ignore: `start` during MEASURE has no effect; `abort` at cycle 100 → `busy`=0 at 101, no `result_valid`/`done`, `result` unchanged.
- `SWEEP_MINMAX_EN`: with the sweep stimulus above, `min_tap`=7 and `max_tap`=0 at `done`. With the macro undefined, both remain 0.
